// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and issue controller for the 3-stage IF/ID/EXE register-file pipeline.
// Tracks the instruction in EXE, stalls IF/ID during multi-cycle ops, drives
// the ID forwarding selects and register-file write port, and keeps counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_we,
  input  logic             id_mc,
  input  logic             exe_redirect,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idexe_load,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic             exe_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] issue_cnt
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ACTIVE  = 2'd1,
    MC_WAIT = 2'd2
  } state_t;

  // MC_WAIT lasts MC_LAT-1 cycles, so the countdown starts at MC_LAT-2.
  localparam logic [3:0] MC_INIT = 4'(MC_LAT - 2);

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [4:0]       exe_rd_q;
  logic             exe_we_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;

  logic stall;
  logic kill;
  logic issue;

  // Hazard decode and datapath control derived from the EXE slot state.
  always_comb begin
    stall      = (state_q == MC_WAIT);
    kill       = (state_q == ACTIVE) & exe_redirect;
    issue      = id_valid & ~stall & ~kill;
    pc_en      = ~stall;
    ifid_en    = ~stall;
    ifid_flush = kill;
    idexe_load = issue;
    exe_busy   = stall;
    rf_we      = (state_q == ACTIVE) & exe_we_q & (exe_rd_q != 5'd0);
    rf_waddr   = exe_rd_q;
    fwd_a      = rf_we & id_use_rs1 & (id_rs1 == exe_rd_q);
    fwd_b      = rf_we & id_use_rs2 & (id_rs2 == exe_rd_q);
  end

  // EXE-slot FSM: occupancy, multi-cycle countdown and destination capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      cnt_q    <= '0;
      exe_rd_q <= '0;
      exe_we_q <= 1'b0;
    end else begin
      case (state_q)
        MC_WAIT: begin
          if (cnt_q == 4'd0) state_q <= ACTIVE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: begin
          if (issue) begin
            exe_rd_q <= id_rd;
            exe_we_q <= id_we;
            if (id_mc) begin
              state_q <= MC_WAIT;
              cnt_q   <= MC_INIT;
            end else begin
              state_q <= ACTIVE;
            end
          end else begin
            state_q <= EMPTY;
          end
        end
      endcase
    end
  end

  // Next values of the wrapping performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(stall);
    issue_cnt_d = issue_cnt_q + CNT_W'(issue);
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic, every cycle compared against a cycle-count based model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MC_LAT = 4;
  localparam int unsigned CNT_W  = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_use_rs1, id_use_rs2, id_we, id_mc;
  logic             exe_redirect;
  logic             pc_en, ifid_en, ifid_flush, idexe_load;
  logic             fwd_a, fwd_b, rf_we, exe_busy;
  logic [4:0]       rf_waddr;
  logic [CNT_W-1:0] stall_cnt, issue_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model: the EXE slot is "occupied" with a number of stall cycles still to go.
  bit               m_occ;
  int unsigned      m_left;
  logic [4:0]       m_rd;
  bit               m_we;
  logic [CNT_W-1:0] m_stalls, m_issues;

  pipeline_hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_mc(id_mc), .exe_redirect(exe_redirect), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idexe_load(idexe_load), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .exe_busy(exe_busy),
    .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_occ = 0; m_left = 0; m_rd = '0; m_we = 0; m_stalls = '0; m_issues = '0;
  endtask

  // Drive one cycle of inputs, compare every output against the model, then
  // advance the model across the rising edge.
  task automatic step(input bit r, input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit u1, input bit u2, input logic [4:0] rd, input bit we,
                      input bit mc, input bit redir);
    bit e_stall, e_active, e_kill, e_issue, e_rfwe;
    @(negedge clk);
    rst = r; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_we = we; id_mc = mc; exe_redirect = redir;
    #1;
    e_stall  = (m_left > 0);
    e_active = m_occ && (m_left == 0);
    e_kill   = e_active && redir;
    e_issue  = v && !e_stall && !e_kill;
    e_rfwe   = e_active && m_we && (m_rd != 5'd0);
    check_eq("pc_en", 64'(pc_en), 64'(!e_stall));
    check_eq("ifid_en", 64'(ifid_en), 64'(!e_stall));
    check_eq("ifid_flush", 64'(ifid_flush), 64'(e_kill));
    check_eq("idexe_load", 64'(idexe_load), 64'(e_issue));
    check_eq("exe_busy", 64'(exe_busy), 64'(e_stall));
    check_eq("rf_we", 64'(rf_we), 64'(e_rfwe));
    if (e_rfwe) check_eq("rf_waddr", 64'(rf_waddr), 64'(m_rd));
    check_eq("fwd_a", 64'(fwd_a), 64'(e_rfwe && u1 && rs1 == m_rd));
    check_eq("fwd_b", 64'(fwd_b), 64'(e_rfwe && u2 && rs2 == m_rd));
    check_eq("stall_cnt", 64'(stall_cnt), 64'(m_stalls));
    check_eq("issue_cnt", 64'(issue_cnt), 64'(m_issues));
    @(posedge clk);
    if (r) begin
      model_clear();
    end else begin
      if (e_stall) m_stalls = m_stalls + 1'b1;
      if (e_issue) m_issues = m_issues + 1'b1;
      if (e_stall) begin
        m_left--;
      end else if (e_issue) begin
        m_occ = 1; m_rd = rd; m_we = we;
        m_left = mc ? MC_LAT - 1 : 0;
      end else begin
        m_occ = 0;
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int unsigned lows;
    rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_we = 0; id_mc = 0; exe_redirect = 0;
    model_clear();
    repeat (2) @(posedge clk);

    // 1: five single-cycle writers x1..x5
    do_reset();
    for (int unsigned i = 1; i <= 5; i++) step(0, 1, 0, 0, 0, 0, 5'(i), 1, 0, 0);
    idle(2);
    check_eq("t1_issue_cnt", 64'(issue_cnt), 64'd5);

    // 2: forwarding of x3 to both sources, then the same with x0
    do_reset();
    step(0, 1, 0, 0, 0, 0, 5'd3, 1, 0, 0);
    step(0, 1, 5'd3, 5'd3, 1, 1, 5'd9, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 5'd0, 1, 0, 0);
    step(0, 1, 5'd0, 5'd0, 1, 1, 5'd9, 1, 0, 0);
    idle(2);

    // 3: multi-cycle writer of x7 followed by a reader held in ID
    do_reset();
    step(0, 1, 0, 0, 0, 0, 5'd7, 1, 1, 0);
    lows = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!pc_en) lows++;
      step(0, 1, 5'd7, 5'd1, 1, 0, 5'd8, 1, 0, 0);
    end
    check_eq("t3_pc_low", 64'(lows), 64'd3);
    idle(1);
    check_eq("t3_stall_cnt", 64'(stall_cnt), 64'd3);

    // 4: redirect in ACTIVE with a valid ID instruction
    do_reset();
    step(0, 1, 0, 0, 0, 0, 5'd4, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 5'd5, 1, 0, 1);
    idle(1);
    check_eq("t4_issue_cnt", 64'(issue_cnt), 64'd1);

    // 5: reset in the second MC_WAIT cycle abandons the op
    do_reset();
    step(0, 1, 0, 0, 0, 0, 5'd6, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    idle(5);

    // 6: back-to-back multi-cycle ops
    do_reset();
    step(0, 1, 0, 0, 0, 0, 5'd10, 1, 1, 0);
    for (int unsigned i = 0; i < 4; i++) step(0, 1, 5'd10, 0, 1, 0, 5'd11, 1, 1, 0);
    idle(5);
    check_eq("t6_stall_cnt", 64'(stall_cnt), 64'd6);

    // Randomized traffic with small register numbers to provoke hazards
    do_reset();
    for (int unsigned i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
           1'($urandom), 1'($urandom), 5'($urandom_range(0, 5)), 1'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and issue controller for the 3-stage IF/ID/EXE pipelined register-file datapath (pipelined_regfile_3stage).
- Tracks the instruction occupying EXE and stalls IF/ID while a multi-cycle EXE operation is in flight.
- Generates the ID operand forwarding selects and the register-file write enable.
- Kills younger instructions on an EXE redirect and keeps stall and issue performance counters.

Parameters:
MC_LAT, 4, total EXE cycles of a multi-cycle op (legal range 2..15)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID stage holds a valid instruction
id_rs1  in  5  ID source register 1
id_rs2  in  5  ID source register 2
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  5  ID destination register
id_we  in  1  instruction writes rd
id_mc  in  1  instruction is multi-cycle
exe_redirect  in  1  EXE instruction is a taken branch/jump
pc_en  out  1  PC may advance
ifid_en  out  1  IF/ID register may load
ifid_flush  out  1  IF/ID register loads a bubble
idexe_load  out  1  ID/EXE register loads the ID instruction
fwd_a  out  1  select EXE result for operand A
fwd_b  out  1  select EXE result for operand B
rf_we  out  1  register-file write enable
rf_waddr  out  5  register-file write address
exe_busy  out  1  a multi-cycle op is pending
stall_cnt  out  CNT_W  cycles with exe_busy=1
issue_cnt  out  CNT_W  instructions issued into EXE

Behaviour:
EXE-slot FSM states:
- EMPTY: no instruction.
- ACTIVE: result available this cycle.
- MC_WAIT: multi-cycle op counting.

Internal registers: state, cnt[3:0], exe_rd, exe_we.

Definitions:
- stall = (state==MC_WAIT).
- issue = id_valid & ~stall & ~kill, where kill = (state==ACTIVE) & exe_redirect.
- exe_redirect is ignored in EMPTY and MC_WAIT.

Transitions each edge (rst has priority):
- rst: state=EMPTY, cnt=0, exe_rd=0, exe_we=0, both counters=0.
- MC_WAIT: if cnt==0 go to ACTIVE, else cnt=cnt-1. No issue occurs.
- EMPTY/ACTIVE with issue & ~id_mc: state=ACTIVE; capture id_rd and id_we.
- EMPTY/ACTIVE with issue & id_mc: state=MC_WAIT, cnt=MC_LAT-2; capture id_rd and id_we.
- EMPTY/ACTIVE with no issue: state=EMPTY.
- A multi-cycle op therefore spends MC_LAT-1 cycles in MC_WAIT plus 1 cycle in ACTIVE. A single-cycle op spends 1 cycle in ACTIVE.

Combinational outputs:
- pc_en = ifid_en = ~stall.
- ifid_flush = kill.
- idexe_load = issue.
- exe_busy = stall.
- rf_we = (state==ACTIVE) & exe_we & (exe_rd!=0).
- rf_waddr = exe_rd.
- fwd_a = rf_we & id_use_rs1 & (id_rs1==exe_rd). fwd_b is the same using rs2.
- Register x0 is never forwarded or written.
- During MC_WAIT no forwarding is possible. The dependent instruction waits in ID and forwards in the ACTIVE cycle.

Counters:
- stall_cnt increments every cycle with stall=1.
- issue_cnt increments on issue.
- Both wrap modulo 2^CNT_W.

Reset values: pc_en=1, ifid_en=1, ifid_flush=0, idexe_load=id_valid, fwd_a=0, fwd_b=0, rf_we=0, rf_waddr=0, exe_busy=0, counters=0.

Boundary cases:
- rst asserted mid MC_WAIT: the op is abandoned, and no rf_we pulse follows.
- Redirect in the same cycle as id_valid: the ID instruction is not issued, and issue_cnt does not increment.
- Back-to-back multi-cycle ops: the second issues in the ACTIVE cycle of the first.
- Both sources equal exe_rd: fwd_a=fwd_b=1.

Test Plan:
1. Reset, then issue 5 single-cycle ops writing x1..x5 -> rf_we=1 for 5 consecutive cycles with rf_waddr=1..5, pc_en stays 1, issue_cnt=5.
2. Issue an op writing x3, then an op reading rs1=x3 and rs2=x3 -> fwd_a=fwd_b=1 in the cycle rf_waddr=3. Repeat with rd=x0 -> fwd_a=fwd_b=0 and rf_we=0.
3. Issue a multi-cycle op (MC_LAT=4) writing x7, followed by a reader of x7 -> pc_en=0 for exactly 3 cycles, then rf_we=1 with rf_waddr=7 and fwd_a=1 in the same cycle, stall_cnt=3.
4. Assert exe_redirect with state ACTIVE while id_valid=1 -> ifid_flush=1, idexe_load=0, EXE is EMPTY the next cycle, and issue_cnt is unchanged.
5. Assert rst during the 2nd MC_WAIT cycle -> the next cycle has exe_busy=0, rf_we never pulses for that op, and both counters read 0.
6. Issue two consecutive multi-cycle ops -> the second idexe_load pulse coincides with the first op's rf_we, and total pc_en-low cycles = 6.
